// File: rtl/cipher_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cipher_round_sequencer
// Purpose  : Walks one block through an iterative cipher core, one round per
//            clock. Issues the block-load strobe, per-round enables, the
//            round-key address (forward for encrypt, reverse for decrypt),
//            the final-round flag and the completion pulse toward the MCU.
//            Counts completed blocks.
// Optional : ROUND_STALL_EN adds input round_stall. It freezes ROUND/FINAL
//            progress while high.
// Ports    : clk, n_reset (async, active-low)
//            key_ready, is_encrypt, blk_valid, tx_full, abort   (inputs)
//            round_stall                          (only with ROUND_STALL_EN)
//            accepted, load_block, round_en, final_round,
//            round_key_addr[KEY_ADDR_W-1:0], data_done, busy,
//            blk_count[CNT_W-1:0]                               (outputs)
// Revision : 1.0 - initial release
// ============================================================================
module cipher_round_sequencer #(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  key_ready,
  input  logic                  is_encrypt,
  input  logic                  blk_valid,
  input  logic                  tx_full,
  input  logic                  abort,
`ifdef ROUND_STALL_EN
  input  logic                  round_stall,
`endif
  output logic                  accepted,
  output logic                  load_block,
  output logic                  round_en,
  output logic                  final_round,
  output logic [KEY_ADDR_W-1:0] round_key_addr,
  output logic                  data_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      blk_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ROUND   = 3'd2,
    S_FINAL   = 3'd3,
    S_WAIT_TX = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Round counter values: the last ROUND cycle and the FINAL cycle.
  localparam logic [KEY_ADDR_W-1:0] PENULT_CNT = KEY_ADDR_W'(NUM_ROUNDS - 2);
  localparam logic [KEY_ADDR_W-1:0] LAST_CNT   = KEY_ADDR_W'(NUM_ROUNDS - 1);

  state_t                  state_q, state_d;
  logic [KEY_ADDR_W-1:0]   rnd_cnt_q, rnd_cnt_d;
  logic                    dir_q, dir_d;
  logic [CNT_W-1:0]        blk_count_q, blk_count_d;
  logic                    stall;

`ifdef ROUND_STALL_EN
  assign stall = round_stall;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      rnd_cnt_q   <= '0;
      dir_q       <= 1'b1;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rnd_cnt_q   <= rnd_cnt_d;
      dir_q       <= dir_d;
      blk_count_q <= blk_count_d;
    end
  end

  always_comb begin
    // Next-state defaults: hold everything.
    state_d     = state_q;
    rnd_cnt_d   = rnd_cnt_q;
    dir_d       = dir_q;
    blk_count_d = blk_count_q;

    // Abort wins over every transition except from IDLE, where it is ignored
    // and also blocks acceptance (no IDLE->LOAD this cycle).
    if (abort) begin
      state_d   = S_IDLE;
      if (state_q != S_IDLE) begin
        rnd_cnt_d = '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (blk_valid && key_ready) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          dir_d     = is_encrypt;
          rnd_cnt_d = '0;
          state_d   = S_ROUND;
        end
        S_ROUND: begin
          if (!stall) begin
            rnd_cnt_d = rnd_cnt_q + 1'b1;
            if (rnd_cnt_q == PENULT_CNT) begin
              state_d = S_FINAL;
            end
          end
        end
        S_FINAL: begin
          if (!stall) begin
            state_d = S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          if (!tx_full) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          blk_count_d = blk_count_q + 1'b1;
          state_d     = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs decode registered state only; the optional stall input is the
    // one deliberate exception, gating the round strobes in the same cycle.
    accepted       = (state_q == S_LOAD);
    load_block     = (state_q == S_LOAD);
    round_en       = ((state_q == S_ROUND) || (state_q == S_FINAL)) && !stall;
    final_round    = (state_q == S_FINAL) && !stall;
    data_done      = (state_q == S_DONE);
    busy           = (state_q != S_IDLE);
    blk_count      = blk_count_q;
    round_key_addr = '0;
    if ((state_q == S_ROUND) || (state_q == S_FINAL)) begin
      round_key_addr = dir_q ? rnd_cnt_q : (LAST_CNT - rnd_cnt_q);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cipher_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_round_sequencer
// Purpose  : Directed, self-checking bench for cipher_round_sequencer with
//            NUM_ROUNDS=16, KEY_ADDR_W=4 and a 4-bit block counter, so the
//            counter wrap is reached in 16 blocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cipher_round_sequencer;

  localparam int NR = 16;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       key_ready, is_encrypt, blk_valid, tx_full, abort, round_stall;
  logic       accepted, load_block, round_en, final_round, data_done, busy;
  logic [3:0] round_key_addr;
  logic [3:0] blk_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  cipher_round_sequencer #(
    .NUM_ROUNDS(NR),
    .KEY_ADDR_W(4),
    .CNT_W     (4)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .key_ready     (key_ready),
    .is_encrypt    (is_encrypt),
    .blk_valid     (blk_valid),
    .tx_full       (tx_full),
    .abort         (abort),
`ifdef ROUND_STALL_EN
    .round_stall   (round_stall),
`endif
    .accepted      (accepted),
    .load_block    (load_block),
    .round_en      (round_en),
    .final_round   (final_round),
    .round_key_addr(round_key_addr),
    .data_done     (data_done),
    .busy          (busy),
    .blk_count     (blk_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_acc"},  32'(accepted), 32'd0);
    chk({tag, "_ren"},  32'(round_en), 32'd0);
    chk({tag, "_done"}, 32'(data_done), 32'd0);
    chk({tag, "_addr"}, 32'(round_key_addr), 32'd0);
  endtask

  // Runs one block from IDLE. Cycle 1 is LOAD. s = stall cycles starting in
  // cycle 5, k = tx_full hold cycles at WAIT_TX entry, abort_at = cycle in
  // which abort is driven (0 = none). noise drives blk_valid high mid-block,
  // drops key_ready for a while and is used to show both are ignored.
  task automatic do_block(input int tid, input bit enc, input int flip_at,
                          input int k, input int s, input int abort_at,
                          input bit noise);
    int  last, cnt, exp_addr;
    bit  in_round, stalled;
    last = 19 + s + k;
    is_encrypt = enc;
    key_ready  = 1'b1;
    blk_valid  = 1'b1;
    tick();
    blk_valid  = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      is_encrypt  = (flip_at != 0 && c >= flip_at) ? ~enc : enc;
      tx_full     = (c >= 18 + s) && (c < 18 + s + k);
      stalled     = (s > 0) && (c >= 5) && (c <= 4 + s);
      round_stall = stalled;
      key_ready   = noise ? !(c >= 6 && c <= 10) : 1'b1;
      blk_valid   = noise && (c >= 3) && (c <= last);
      abort       = (c == abort_at);
      in_round    = (c >= 2) && (c <= 17 + s);
      cnt         = (c < 5) ? c - 2 : ((c <= 4 + s) ? 3 : c - 2 - s);
      exp_addr    = in_round ? (enc ? cnt : (NR - 1 - cnt)) : 0;
      chk($sformatf("t%0d_c%0d_acc",  tid, c), 32'(accepted),    32'(c == 1));
      chk($sformatf("t%0d_c%0d_load", tid, c), 32'(load_block),  32'(c == 1));
      chk($sformatf("t%0d_c%0d_ren",  tid, c), 32'(round_en),    32'(in_round && !stalled));
      chk($sformatf("t%0d_c%0d_fin",  tid, c), 32'(final_round), 32'(c == 17 + s));
      chk($sformatf("t%0d_c%0d_addr", tid, c), 32'(round_key_addr), 32'(exp_addr));
      chk($sformatf("t%0d_c%0d_done", tid, c), 32'(data_done),   32'(c == last));
      chk($sformatf("t%0d_c%0d_busy", tid, c), 32'(busy),        32'(c >= 1 && c <= last));
      if (c == abort_at) begin
        tick();
        abort = 1'b0;
        chk_idle($sformatf("t%0d_abort", tid));
        chk($sformatf("t%0d_abort_cnt", tid), 32'(blk_count), 32'(exp_cnt % 16));
        break;
      end
      if (c <= last) tick();
    end
    blk_valid = 1'b0; tx_full = 1'b0; round_stall = 1'b0; key_ready = 1'b1; abort = 1'b0;
    if (abort_at == 0) begin
      exp_cnt++;
      chk($sformatf("t%0d_blkcnt", tid), 32'(blk_count), 32'(exp_cnt % 16));
    end
  endtask

  initial begin
    n_reset = 1'b0; key_ready = 1'b0; is_encrypt = 1'b0; blk_valid = 1'b0;
    tx_full = 1'b0; abort = 1'b0; round_stall = 1'b0;
    tick(); tick();
    chk_idle("rst_hold");
    chk("rst_cnt", 32'(blk_count), 32'd0);
    n_reset = 1'b1;
    tick();
    chk_idle("post_rst");
    chk("post_rst_fin", 32'(final_round), 32'd0);

    // 1: encrypt, forward key order, blk_valid noise ignored mid-block.
    do_block(1, 1'b1, 0, 0, 0, 0, 1'b1);
    // 2: decrypt, is_encrypt flipped in cycle 5 has no effect.
    do_block(2, 1'b0, 5, 0, 0, 0, 1'b0);

    // 3: key not ready -> no accept while blk_valid held 5 cycles.
    key_ready = 1'b0; blk_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3_wait%0d_acc", i), 32'(accepted), 32'd0);
      chk($sformatf("t3_wait%0d_busy", i), 32'(busy), 32'd0);
    end
    key_ready = 1'b1;
    tick();
    blk_valid = 1'b0;
    chk("t3_load_acc", 32'(accepted), 32'd1);
    chk("t3_load_lb",  32'(load_block), 32'd1);
    abort = 1'b1;                 // abort out of LOAD
    tick();
    abort = 1'b0;
    chk_idle("t3_abort_load");
    chk("t3_cnt", 32'(blk_count), 32'(exp_cnt % 16));

    // abort in IDLE blocks acceptance that cycle.
    abort = 1'b1; blk_valid = 1'b1;
    tick();
    abort = 1'b0; blk_valid = 1'b0;
    chk_idle("idle_abort");
    tick();
    chk_idle("idle_abort2");

    // 4: tx_full held 4 cycles at WAIT_TX entry -> data_done in cycle 23.
    do_block(4, 1'b1, 0, 4, 0, 0, 1'b0);
    // 5: abort in cycle 8, then a new block accepted immediately.
    do_block(5, 1'b1, 0, 0, 0, 8, 1'b0);
    do_block(6, 1'b0, 0, 0, 0, 0, 1'b0);
`ifdef ROUND_STALL_EN
    do_block(7, 1'b1, 0, 0, 3, 0, 1'b0);
    do_block(8, 1'b0, 0, 2, 3, 0, 1'b0);
`endif

    // 6: back-to-back blocks until the 4-bit counter wraps to 0.
    while (exp_cnt < 16) begin
      do_block(9, exp_cnt[0], 0, 0, 0, 0, 1'b0);
    end
    chk("wrap_zero", 32'(blk_count), 32'd0);
    do_block(10, 1'b1, 0, 0, 0, 0, 1'b0);
    chk("after_wrap", 32'(blk_count), 32'd1);

    // Reset mid-ROUND: immediate return to reset values.
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_ren", 32'(round_en), 32'd1);
    n_reset = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_cnt", 32'(blk_count), 32'd0);
    tick();
    n_reset = 1'b1;
    tick();
    chk_idle("rst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
